spi_memory_read_sequencer: RTL and testbench
============================================

// Module: spi_memory_read_sequencer
// PURPOSE
//  Sequences one complete read transaction on spi_memory_master: command phase, N data bytes, then finalize.
//  It accepts a single request (opcode, optional address, dummy cycles, byte count) from the frame/config logic.
//  It streams the received bytes out, one per out_valid pulse, and raises done or error at the end.
//  It owns every trigger input of spi_memory_master. No other block drives those triggers.
// PARAMETERS
//  CNT_W      8     width of byte_count; 0 means no data phase
//  TIMEOUT    4096  main_clock cycles allowed per phase before the transaction aborts with error
// PORTS
//  main_clock            in   1      system clock; all logic on posedge
//  nreset                in   1      asynchronous, active-low reset
//  start                 in   1      1-cycle request pulse; ignored unless ready=1
//  req_opcode            in   8      opcode; captured on start
//  req_addr              in   8      address; captured on start
//  req_addr_en           in   1      1 = send the address after the opcode; captured on start
//  req_dummy             in   8      dummy cycles; captured on start
//  byte_count            in   CNT_W  number of bytes to read; captured on start
//  ready                 out  1      1 only in IDLE
//  out_data              out  8      received byte; valid while out_valid=1
//  out_valid             out  1      1-cycle pulse per received byte
//  done                  out  1      1-cycle pulse when the transaction ends normally
//  error                 out  1      1-cycle pulse when the transaction ends on timeout
//  opcode, addr, dummy_cycles, addr_flag  out  8,8,8,1  to master; registered copies of the request
//  opcode_addr_trigger   out  1      to master
//  opcode_addr_completed in   1      from master
//  data_trigger          out  1      to master
//  data_ready            in   1      from master; level, one rising edge per byte
//  read_data             in   8      from master
//  finalize_trigger      out  1      to master
//  busy                  in   1      from master
// BEHAVIOUR
//  Reset: state=IDLE, ready=1. All other outputs and all triggers are 0. Request registers are 0. Counter is 0.
//  nreset asserted mid-transaction: all triggers drop immediately; no done/error pulse is issued.
//  IDLE: on start, capture the request, load remaining=byte_count, go to CMD.
//  CMD: opcode_addr_trigger=1 (level) until opcode_addr_completed=1 is sampled.
//   - The trigger drops in the next cycle.
//   - If remaining=0, go to FINAL; otherwise go to DATA.
//  DATA: data_trigger = (remaining!=0), combinational from the counter.
//   - Rising edge of data_ready is detected with a 1-cycle prev register.
//   - On that edge: out_data<=read_data, out_valid pulses 1 cycle later, remaining decrements.
//   - The decrement drops data_trigger in the same cycle, so the master never starts byte N+1.
//   - When remaining reaches 0: wait for data_ready=0, then go to FINAL.
//  FINAL: finalize_trigger=1 until busy=0 has been sampled after at least one cycle of busy=1.
//   - If busy is never seen high, FINAL exits after 2 cycles of busy=0.
//   - Then go to DONE.
//  DONE: done=1 for 1 cycle, then IDLE; ready=1 again on the following cycle.
//  Timeout: a cycle counter clears on every state change and on every byte.
//   - If it reaches TIMEOUT-1 in CMD, DATA or FINAL: drop all triggers, pulse error 1 cycle, go to IDLE.
//   - No done pulse is issued on timeout.
//  start outside IDLE: ignored, with no effect on the running transaction.
//  byte_count = 2^CNT_W-1: exactly that many bytes are delivered; the counter never wraps.
//  out_valid has no backpressure. The consumer must accept each byte in the cycle it is presented.
// TESTING
//  1. JEDEC ID: opcode 9F, addr_en=0, count=3, slave returns EF,40,18.
//     -> out bytes EF,40,18; exactly 3 data_ready edges; done pulses once; addr_flag=0.
//  2. Read: opcode 03, addr AB, addr_en=1, count=1, MISO held 1.
//     -> addr_flag=1, addr=AB; one out byte FF; data_trigger low before the 2nd byte; done.
//  3. count=0, opcode 06.
//     -> data_trigger never asserts; finalize follows the command phase; done; no out_valid.
//  4. Hold opcode_addr_completed=0 (TIMEOUT=64).
//     -> error pulses at cycle 64 of CMD; all triggers 0; ready=1; no done.
//  5. start pulsed again during DATA, then nreset pulled low mid-byte.
//     -> the second start is ignored; triggers drop asynchronously; IDLE after release.
//  6. Back-to-back: start the next request the cycle after ready rises.
//     -> both transactions complete, and the byte counts are correct for each.

Source files
------------

// File: rtl/spi_memory_read_sequencer.sv
// Drives spi_memory_master through one read transaction: command phase, N data bytes, finalize.
// Received bytes stream out one per out_valid pulse; done or error closes the transaction.
module spi_memory_read_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             main_clock,
    input  logic             nreset,
    input  logic             start,
    input  logic [7:0]       req_opcode,
    input  logic [7:0]       req_addr,
    input  logic             req_addr_en,
    input  logic [7:0]       req_dummy,
    input  logic [CNT_W-1:0] byte_count,
    output logic             ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             done,
    output logic             error,
    output logic [7:0]       opcode,
    output logic [7:0]       addr,
    output logic [7:0]       dummy_cycles,
    output logic             addr_flag,
    output logic             opcode_addr_trigger,
    input  logic             opcode_addr_completed,
    output logic             data_trigger,
    input  logic             data_ready,
    input  logic [7:0]       read_data,
    output logic             finalize_trigger,
    input  logic             busy
);

    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CMD, DATA, FINAL, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [TW-1:0]    tcnt;
    logic             dr_prev;
    logic             busy_seen;
    logic             busy_low1;
    logic             dr_rise;
    logic             expired;
    logic             active;

    assign ready        = (state == IDLE);
    assign data_trigger = (state == DATA) && (remaining != '0);
    assign dr_rise      = data_ready && !dr_prev;
    assign expired      = (tcnt == T_LAST);
    assign active       = (state == CMD) || (state == DATA) || (state == FINAL);

    always_ff @(posedge main_clock or negedge nreset) begin
        if (!nreset) begin
            state               <= IDLE;
            remaining           <= '0;
            tcnt                <= '0;
            dr_prev             <= 1'b0;
            busy_seen           <= 1'b0;
            busy_low1           <= 1'b0;
            out_data            <= '0;
            out_valid           <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            opcode              <= '0;
            addr                <= '0;
            dummy_cycles        <= '0;
            addr_flag           <= 1'b0;
            opcode_addr_trigger <= 1'b0;
            finalize_trigger    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            dr_prev   <= data_ready;

            // A phase that stalls for TIMEOUT cycles aborts straight to IDLE with no done pulse.
            if (active && expired) begin
                opcode_addr_trigger <= 1'b0;
                finalize_trigger    <= 1'b0;
                remaining           <= '0;
                tcnt                <= '0;
                error               <= 1'b1;
                state               <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (start) begin
                            opcode              <= req_opcode;
                            addr                <= req_addr;
                            addr_flag           <= req_addr_en;
                            dummy_cycles        <= req_dummy;
                            remaining           <= byte_count;
                            opcode_addr_trigger <= 1'b1;
                            state               <= CMD;
                        end
                    end
                    CMD: begin
                        if (opcode_addr_completed) begin
                            opcode_addr_trigger <= 1'b0;
                            tcnt                <= '0;
                            if (remaining == '0) begin
                                finalize_trigger <= 1'b1;
                                busy_seen        <= 1'b0;
                                busy_low1        <= 1'b0;
                                state            <= FINAL;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    DATA: begin
                        // Decrementing here drops data_trigger before the master can begin another byte.
                        if (data_trigger && dr_rise) begin
                            out_data  <= read_data;
                            out_valid <= 1'b1;
                            remaining <= remaining - 1'b1;
                            tcnt      <= '0;
                        end else if ((remaining == '0) && !data_ready) begin
                            finalize_trigger <= 1'b1;
                            busy_seen        <= 1'b0;
                            busy_low1        <= 1'b0;
                            tcnt             <= '0;
                            state            <= FINAL;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    FINAL: begin
                        // Exit on busy falling, or after two idle cycles if the master never went busy.
                        if (busy) begin
                            busy_seen <= 1'b1;
                            tcnt      <= tcnt + 1'b1;
                        end else if (busy_seen || busy_low1) begin
                            finalize_trigger <= 1'b0;
                            done             <= 1'b1;
                            tcnt             <= '0;
                            state            <= DONE;
                        end else begin
                            busy_low1 <= 1'b1;
                            tcnt      <= tcnt + 1'b1;
                        end
                    end
                    DONE: begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_memory_read_sequencer.sv
// Bench for spi_memory_read_sequencer: behavioural master responders, byte/end scoreboard,
// directed transactions followed by randomized ones.
module tb_spi_memory_read_sequencer;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             main_clock = 1'b0;
    logic             nreset     = 1'b0;
    logic             start      = 1'b0;
    logic [7:0]       req_opcode = '0;
    logic [7:0]       req_addr   = '0;
    logic             req_addr_en = 1'b0;
    logic [7:0]       req_dummy  = '0;
    logic [CNT_W-1:0] byte_count = '0;
    logic             ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             done;
    logic             error;
    logic [7:0]       opcode;
    logic [7:0]       addr;
    logic [7:0]       dummy_cycles;
    logic             addr_flag;
    logic             opcode_addr_trigger;
    logic             opcode_addr_completed = 1'b0;
    logic             data_trigger;
    logic             data_ready = 1'b0;
    logic [7:0]       read_data  = '0;
    logic             finalize_trigger;
    logic             busy       = 1'b0;

    spi_memory_read_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .main_clock(main_clock), .nreset(nreset), .start(start),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_addr_en(req_addr_en),
        .req_dummy(req_dummy), .byte_count(byte_count), .ready(ready),
        .out_data(out_data), .out_valid(out_valid), .done(done), .error(error),
        .opcode(opcode), .addr(addr), .dummy_cycles(dummy_cycles), .addr_flag(addr_flag),
        .opcode_addr_trigger(opcode_addr_trigger), .opcode_addr_completed(opcode_addr_completed),
        .data_trigger(data_trigger), .data_ready(data_ready), .read_data(read_data),
        .finalize_trigger(finalize_trigger), .busy(busy)
    );

    always #5 main_clock = ~main_clock;

    int         n_cmp = 0;
    int         n_err = 0;
    int         edge_cnt = 0;
    bit         dt_seen = 1'b0;
    bit         end_seen = 1'b0;
    bit         cmd_hang = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] slave_q[$];
    logic [7:0] pat_q[$];
    int         end_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Master: command phase completes after a short random delay.
    initial forever begin
        @(negedge main_clock);
        if (nreset && opcode_addr_trigger && !cmd_hang) begin
            repeat ($urandom_range(0, 3)) @(negedge main_clock);
            opcode_addr_completed = 1'b1;
            @(negedge main_clock);
            opcode_addr_completed = 1'b0;
        end
    end

    // Master: one byte per data_trigger, each as a data_ready high pulse.
    initial forever begin
        @(negedge main_clock);
        if (nreset && data_trigger) begin
            repeat ($urandom_range(0, 2)) @(negedge main_clock);
            read_data  = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            data_ready = 1'b1;
            edge_cnt++;
            repeat ($urandom_range(1, 3)) @(negedge main_clock);
            data_ready = 1'b0;
        end
    end

    // Master: finalize either pulses busy for a few cycles or never raises it.
    initial forever begin
        @(negedge main_clock);
        if (nreset && finalize_trigger) begin
            if ($urandom_range(0, 1) == 1) begin
                busy = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge main_clock);
                busy = 1'b0;
            end
            for (int k = 0; k < 50 && finalize_trigger && nreset; k++) @(negedge main_clock);
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge main_clock);
        if (nreset) begin
            if (data_trigger) dt_seen = 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL out_byte: got %02h, required no byte", out_data);
                end else begin
                    check("out_byte", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (done || error) begin
                if (end_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL end_kind: got done=%0b error=%0b, required none", done, error);
                end else begin
                    check("end_kind", int'({error, done}), end_q.pop_front());
                end
                end_seen = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin @(negedge main_clock); n++; end
        check("ready_wait", int'(ready), 1);
    endtask

    task automatic start_req(input logic [7:0] op, input logic [7:0] ad, input logic aen,
                             input logic [7:0] dm, input int cnt, input bit with_bytes);
        logic [7:0] b;
        edge_cnt = 0;
        dt_seen  = 1'b0;
        end_seen = 1'b0;
        if (with_bytes) begin
            for (int i = 0; i < cnt; i++) begin
                b = (pat_q.size() != 0) ? pat_q.pop_front() : 8'($urandom);
                slave_q.push_back(b);
                exp_q.push_back(b);
            end
        end
        req_opcode  = op;
        req_addr    = ad;
        req_addr_en = aen;
        req_dummy   = dm;
        byte_count  = CNT_W'(cnt);
        start       = 1'b1;
        @(negedge main_clock);
        start       = 1'b0;
        req_opcode  = 8'($urandom);
        req_addr    = 8'($urandom);
        req_addr_en = 1'($urandom);
        req_dummy   = 8'($urandom);
        byte_count  = CNT_W'($urandom);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [7:0] ad, input logic aen,
                           input logic [7:0] dm, input int cnt, input bit inject);
        int n;
        wait_ready();
        end_q.push_back(1);
        start_req(op, ad, aen, dm, cnt, 1'b1);
        if (inject) begin
            n = 0;
            while (edge_cnt < 1 && n < 500) begin @(negedge main_clock); n++; end
            check("inject_busy", int'(ready), 0);
            req_opcode  = ~op;
            req_addr    = ~ad;
            req_addr_en = ~aen;
            byte_count  = '0;
            start       = 1'b1;
            @(negedge main_clock);
            start       = 1'b0;
        end
        n = 0;
        while (!end_seen && n < 4000) begin @(negedge main_clock); n++; end
        check("end_seen", int'(end_seen), 1);
        check("edges", edge_cnt, cnt);
        check("bytes_left", exp_q.size(), 0);
        check("opcode", int'(opcode), int'(op));
        check("addr", int'(addr), int'(ad));
        check("addr_flag", int'(addr_flag), int'(aen));
        check("dummy", int'(dummy_cycles), int'(dm));
        if (cnt == 0) check("no_data_trig", int'(dt_seen), 0);
    endtask

    initial begin
        int n;
        int cnt;
        repeat (2) @(negedge main_clock);
        check("rst_ready", int'(ready), 1);
        check("rst_outs", int'({out_valid, done, error}), 0);
        check("rst_trig", int'({opcode_addr_trigger, data_trigger, finalize_trigger}), 0);
        check("rst_req", int'({opcode, addr, dummy_cycles, addr_flag}), 0);
        nreset = 1'b1;
        @(negedge main_clock);
        check("idle_ready", int'(ready), 1);

        // JEDEC ID, single-byte read with address, zero-length command.
        pat_q = '{8'hEF, 8'h40, 8'h18};
        run_txn(8'h9F, 8'h00, 1'b0, 8'h00, 3, 1'b0);
        pat_q = '{8'hFF};
        run_txn(8'h03, 8'hAB, 1'b1, 8'h00, 1, 1'b0);
        run_txn(8'h06, 8'h00, 1'b0, 8'h00, 0, 1'b0);

        // Command phase never completes.
        wait_ready();
        cmd_hang = 1'b1;
        end_q.push_back(2);
        start_req(8'h05, 8'h00, 1'b0, 8'h00, 2, 1'b0);
        check("cmd_trig", int'(opcode_addr_trigger), 1);
        n = 0;
        while (!error && n < 200) begin @(negedge main_clock); n++; end
        check("timeout_cycle", n, 64);
        check("to_trig", int'({opcode_addr_trigger, data_trigger, finalize_trigger}), 0);
        check("to_ready", int'(ready), 1);
        @(negedge main_clock);
        check("to_pulse", int'({error, done}), 0);
        cmd_hang = 1'b0;

        // Stray start during DATA must not disturb the transaction.
        run_txn(8'h0B, 8'h33, 1'b1, 8'h08, 4, 1'b1);

        // Reset in the middle of a byte.
        wait_ready();
        start_req(8'h0B, 8'h10, 1'b1, 8'h08, 6, 1'b1);
        n = 0;
        while (!(data_ready && edge_cnt >= 2) && n < 500) begin
            @(negedge main_clock); #1; n++;
        end
        check("mid_byte", int'(data_ready), 1);
        #1 nreset = 1'b0;
        #1;
        check("arst_trig", int'({opcode_addr_trigger, data_trigger, finalize_trigger}), 0);
        check("arst_ready", int'(ready), 1);
        check("arst_valid", int'(out_valid), 0);
        check("arst_opcode", int'(opcode), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge main_clock);
            check("arst_no_end", int'({error, done}), 0);
        end
        exp_q.delete();
        slave_q.delete();
        end_q.delete();
        nreset = 1'b1;
        repeat (4) @(negedge main_clock);
        check("post_rst_ready", int'(ready), 1);
        check("post_rst_trig", int'({opcode_addr_trigger, data_trigger, finalize_trigger}), 0);

        // Back-to-back requests, then the full-range byte count.
        run_txn(8'h3B, 8'h40, 1'b1, 8'h04, 3, 1'b0);
        run_txn(8'h0B, 8'h41, 1'b1, 8'h02, 2, 1'b0);
        run_txn(8'h03, 8'h00, 1'b1, 8'h00, 255, 1'b0);

        for (int t = 0; t < 12; t++) begin
            cnt = $urandom_range(0, 9);
            run_txn(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), cnt,
                    (cnt >= 3) && ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge main_clock);
        check("final_end_q", end_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
